calc_op_sequencer: RTL and testbench

- Multi-cycle operation controller in front of the calculator result/display mux.
- Latches two W-bit operands and a 2-bit opcode on a start strobe.
- Executes add/sub in one cycle and mul/div as W-step shift-add / restoring-divide loops.
- Presents the 2W-bit result plus a held opcode to the display mux; for divide, the packing is quotient in res[11:6] and remainder in res[5:0].

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_iter_unit.sv | 80 ++++++++
 rtl/calc_op_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcode, FSM-state and result constants for the calculator op sequencer.
// Optional pending-request buffer in the top is enabled by CALC_PENDING_REQ_EN.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Divide result packing assumes 6-bit operands (12-bit result word).
    localparam int unsigned DIV_W = 6;
    localparam logic [2*DIV_W-1:0] DIV0_RESULT = '1;

    // Multiply and non-zero divide go through the iterative loop; everything else finishes directly.
    function automatic logic needs_exec(input logic [1:0] op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative datapath for the op sequencer: shift-add multiply and restoring divide,
// one step per cycle, W steps per operation.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           init,
    input  logic           step,
    input  logic [1:0]     op,
    input  logic [W-1:0]   dividend,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] acc,
    output logic [W-1:0]   quo,
    output logic [W-1:0]   rem,
    output logic           last_step
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   dq_q, dq_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W:0]     trial;
    logic [2*W-1:0] partial;

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        // Trial remainder is one bit wider so a large divisor cannot overflow the shift.
        trial   = {rem_q, dq_q[W-1]};
        partial = b[cnt_q] ? ({{W{1'b0}}, a} << cnt_q) : '0;
        if (init) begin
            cnt_d = '0;
            acc_d = '0;
            rem_d = '0;
            dq_d  = dividend;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (op == OP_DIV) begin
                if (trial >= {1'b0, b}) begin
                    rem_d = W'(trial - {1'b0, b});
                    dq_d  = {dq_q[W-2:0], 1'b1};
                end else begin
                    rem_d = trial[W-1:0];
                    dq_d  = {dq_q[W-2:0], 1'b0};
                end
            end else begin
                acc_d = acc_q + partial;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            dq_q  <= '0;
            rem_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            dq_q  <= dq_d;
            rem_q <= rem_d;
        end
    end

    assign acc       = acc_q;
    assign quo       = dq_q;
    assign rem       = rem_q;
    assign last_step = (cnt_q == LAST_CNT);

endmodule

// File: rtl/calc_op_sequencer.sv
// Multi-cycle add/sub/mul/div controller feeding the calculator display mux.
// Define CALC_PENDING_REQ_EN to add a one-entry buffer for starts issued while busy.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    input  logic [1:0]     op_sel,
    output logic [2*W-1:0] res,
    output logic [1:0]     res_sel,
    output logic           neg,
    output logic           err,
    output logic           busy,
    output logic           done
);

    localparam int unsigned RW = 2 * W;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic [RW-1:0] res_q, res_d;
    logic [1:0]    sel_q, sel_d;
    logic          neg_q, neg_d, err_q, err_d, done_q, done_d;

    logic          launch;
    logic [W-1:0]  ln_a, ln_b;
    logic [1:0]    ln_op;
    logic          iter_init, iter_step, last_step;
    logic [RW-1:0] acc;
    logic [W-1:0]  quo, rem;

`ifdef CALC_PENDING_REQ_EN
    logic          pend_valid_q, pend_valid_d, ovf_q, ovf_d;
    logic [W-1:0]  pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [1:0]    pend_op_q, pend_op_d;

    // FINISH hands off to the buffered request first, else to a start arriving that cycle.
    always_comb begin
        launch = 1'b0;
        ln_a   = op_a;
        ln_b   = op_b;
        ln_op  = op_sel;
        if (state_q == ST_IDLE) begin
            launch = start;
        end else if (state_q == ST_FINISH) begin
            if (pend_valid_q) begin
                launch = 1'b1;
                ln_a   = pend_a_q;
                ln_b   = pend_b_q;
                ln_op  = pend_op_q;
            end else begin
                launch = start;
            end
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_a_d     = pend_a_q;
        pend_b_d     = pend_b_q;
        pend_op_d    = pend_op_q;
        ovf_d        = ovf_q;
        if (state_q == ST_FINISH && pend_valid_q) begin
            pend_valid_d = 1'b0;
        end
        if (start && state_q != ST_IDLE && !(state_q == ST_FINISH && !pend_valid_q)) begin
            if (!pend_valid_d) begin
                pend_valid_d = 1'b1;
                pend_a_d     = op_a;
                pend_b_d     = op_b;
                pend_op_d    = op_sel;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_a_q     <= '0;
            pend_b_q     <= '0;
            pend_op_q    <= OP_ADD;
            ovf_q        <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            pend_op_q    <= pend_op_d;
            ovf_q        <= ovf_d;
        end
    end
`else
    always_comb begin
        launch = (state_q == ST_IDLE) && start;
        ln_a   = op_a;
        ln_b   = op_b;
        ln_op  = op_sel;
    end
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        sel_d     = sel_q;
        neg_d     = neg_q;
        err_d     = err_q;
        done_d    = 1'b0;
        iter_init = 1'b0;
        iter_step = 1'b0;
        case (state_q)
            ST_EXEC: begin
                iter_step = 1'b1;
                if (last_step) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                sel_d   = op_q;
                neg_d   = 1'b0;
                err_d   = 1'b0;
                case (op_q)
                    OP_ADD: res_d = RW'({1'b0, a_q} + {1'b0, b_q});
                    OP_SUB: begin
                        res_d = RW'((a_q >= b_q) ? (a_q - b_q) : (b_q - a_q));
                        neg_d = (a_q < b_q);
                    end
                    OP_MUL: res_d = acc;
                    default: begin
                        if (b_q == '0) begin
                            res_d = RW'(DIV0_RESULT);
                            err_d = 1'b1;
                        end else begin
                            res_d = {quo, rem};
                        end
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
        if (launch) begin
            a_d  = ln_a;
            b_d  = ln_b;
            op_d = ln_op;
            if (needs_exec(ln_op, ln_b == '0)) begin
                state_d   = ST_EXEC;
                iter_init = 1'b1;
            end else begin
                state_d = ST_FINISH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            res_q   <= '0;
            sel_q   <= OP_ADD;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            sel_q   <= sel_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    calc_iter_unit #(
        .W(W)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (iter_init),
        .step      (iter_step),
        .op        (op_q),
        .dividend  (ln_a),
        .a         (a_q),
        .b         (b_q),
        .acc       (acc),
        .quo       (quo),
        .rem       (rem),
        .last_step (last_step)
    );

    assign res     = res_q;
    assign res_sel = sel_q;
    assign neg     = neg_q;
    assign err     = err_q;
    assign done    = done_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: directed ops push expected results,
// a monitor pops and compares on every done pulse, including the cycle it arrives.
module tb_calc_op_sequencer;

    localparam int unsigned W = 6;

    typedef struct {
        logic [11:0] res;
        logic [1:0]  sel;
        logic        neg;
        logic        err;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op_a = '0;
    logic [5:0]  op_b = '0;
    logic [1:0]  op_sel = '0;
    logic [11:0] res;
    logic [1:0]  res_sel;
    logic        neg, err, busy, done;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    calc_op_sequencer #(
        .W(W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .op_sel  (op_sel),
        .res     (res),
        .res_sel (res_sel),
        .neg     (neg),
        .err     (err),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 (res=%0h) expected no pulse", res);
            end else begin
                mon_e = sb.pop_front();
                chk("res", {20'd0, res}, {20'd0, mon_e.res});
                chk("res_sel", {30'd0, res_sel}, {30'd0, mon_e.sel});
                chk("neg", {31'd0, neg}, {31'd0, mon_e.neg});
                chk("err", {31'd0, err}, {31'd0, mon_e.err});
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Accepted on the posedge after the driving negedge; done expected lat cycles later.
    task automatic issue(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op,
                         input int unsigned lat, input logic [11:0] eres, input logic eneg,
                         input logic eerr, input bit expect_done, output int unsigned k);
        exp_t e;
        @(negedge clk);
        op_a   = a;
        op_b   = b;
        op_sel = op;
        start  = 1'b1;
        k      = cyc;
        if (expect_done) begin
            e.res = eres;
            e.sel = op;
            e.neg = eneg;
            e.err = eerr;
            e.cyc = k + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_res"}, {20'd0, res}, 32'd0);
        chk({tag, "_res_sel"}, {30'd0, res_sel}, 32'd0);
        chk({tag, "_neg"}, {31'd0, neg}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        exp_t e;

        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(6'd23, 6'd17, 2'b00, 2, 12'h028, 1'b0, 1'b0, 1'b1, k);
        drain("add");
        issue(6'd63, 6'd63, 2'b00, 2, 12'h07E, 1'b0, 1'b0, 1'b1, k);
        drain("add_carry");
        issue(6'd10, 6'd25, 2'b01, 2, 12'h00F, 1'b1, 1'b0, 1'b1, k);
        drain("sub_neg");
        issue(6'd25, 6'd10, 2'b01, 2, 12'h00F, 1'b0, 1'b0, 1'b1, k);
        drain("sub_pos");
        issue(6'd9, 6'd9, 2'b01, 2, 12'h000, 1'b0, 1'b0, 1'b1, k);
        drain("sub_zero");

        // Multiply with busy tracking and a start pulsed mid-operation.
        issue(6'd63, 6'd63, 2'b10, 8, 12'hF81, 1'b0, 1'b0, 1'b1, k);
        chk("mul_busy", {31'd0, busy}, 32'd1);
        for (int i = 2; i <= 7; i++) begin
            @(negedge clk);
            chk("mul_busy", {31'd0, busy}, 32'd1);
            if (i == 3) begin
                op_a   = 6'd1;
                op_b   = 6'd2;
                op_sel = 2'b00;
                start  = 1'b1;
`ifdef CALC_PENDING_REQ_EN
                e.res = 12'h003;
                e.sel = 2'b00;
                e.neg = 1'b0;
                e.err = 1'b0;
                e.cyc = k + 9;
                sb.push_back(e);
`endif
            end else if (i == 4) begin
                start = 1'b0;
            end
        end
        drain("mul");
`ifndef CALC_PENDING_REQ_EN
        chk("mul_idle_busy", {31'd0, busy}, 32'd0);
`endif

        issue(6'd45, 6'd7, 2'b11, 8, 12'h183, 1'b0, 1'b0, 1'b1, k);
        drain("div");
        issue(6'd12, 6'd0, 2'b11, 2, 12'hFFF, 1'b0, 1'b1, 1'b1, k);
        drain("div0");
        issue(6'd1, 6'd1, 2'b00, 2, 12'h002, 1'b0, 1'b0, 1'b1, k);
        drain("err_clear");

        // Start in the FINISH cycle is ignored; the next cycle (first IDLE) is accepted.
        issue(6'd3, 6'd4, 2'b00, 2, 12'h007, 1'b0, 1'b0, 1'b1, k);
`ifndef CALC_PENDING_REQ_EN
        op_a   = 6'd7;
        op_b   = 6'd7;
        op_sel = 2'b10;
        start  = 1'b1;
`endif
        issue(6'd20, 6'd30, 2'b01, 2, 12'h00A, 1'b1, 1'b0, 1'b1, k);
        drain("back_to_back");

        // Reset mid-divide discards the operation and clears outputs immediately.
        issue(6'd45, 6'd7, 2'b11, 8, 12'h000, 1'b0, 1'b0, 1'b0, k);
        repeat (3) @(negedge clk);
        chk("mid_cycle", cyc, k + 4);
        rst_n = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_idle", {31'd0, busy}, 32'd0);
        issue(6'd5, 6'd5, 2'b00, 2, 12'h00A, 1'b0, 1'b0, 1'b1, k);
        drain("post_reset_add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
